// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM stage and a single-port data memory.
// Aligns narrow stores onto byte lanes and extracts/extends narrow loads.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misalign;
  logic [4:0]  r_rd;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;

  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = req_wdata;
    case (req_size)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << req_addr[1:0];
        w_wdata   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = ~req_addr[0];
        w_be      = 4'b0011 << req_addr[1:0];
        w_wdata   = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_aligned = (req_addr[1:0] == 2'b00);
      end
      default: begin
        w_aligned = 1'b0;
      end
    endcase
  end

  // Lane selection uses the offset latched at request time.
  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_rdata;
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
      r_rd        <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_off       <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_aligned) begin
              r_rd        <= req_rd;
              r_size      <= req_size;
              r_uns       <= req_unsigned;
              r_off       <= req_addr[1:0];
              r_mem_en    <= 1'b1;
              r_mem_we    <= req_write;
              r_mem_addr  <= {req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_state     <= ACCESS;
            end else begin
              r_misalign <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= IDLE;
            if (!r_mem_we) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_load;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign stall        = (r_state == ACCESS);
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed corner cases plus random
// transactions checked against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
      input logic uns, input int off, input logic [31:0] w);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    if (nb == 4) return w;
    v = (w >> (8 * off)) & ((32'h1 << (8 * nb)) - 32'h1);
    if (!uns && v >= (32'h1 << (8 * nb - 1)))
      v = v - (32'h1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz,
      input logic [31:0] wd);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v = '0;
    for (int k = 0; k < 4; k++)
      v[8*k +: 8] = wd[8*(k % nb) +: 8];
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz,
      input int off);
    int nb;
    nb = 1 << sz;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_be"}, 32'(mem_be), 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wbv"}, 32'(wb_valid), 0);
    chk({tag, "_wbrd"}, 32'(wb_rd), 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_mis"}, 32'(misalign_err), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz,
      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
      input logic [4:0] rd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
  endtask

  task automatic xfer(input logic wr, input logic [1:0] sz,
      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
      input logic [4:0] rd, input logic [31:0] rdata, input int waits);
    bit ok;
    int off;
    logic [31:0] exp_ld;
    ok = (sz != 2'b11) && ((addr % (1 << sz)) == 0);
    off = int'(addr % 4);
    exp_ld = ref_load(sz, uns, off, rdata);
    drive_req(wr, sz, uns, addr, wd, rd);
    tick();
    req_valid = 1'b0;
    if (!ok) begin
      chk("mis_err", 32'(misalign_err), 1);
      chk("mis_en", 32'(mem_en), 0);
      chk("mis_stall", 32'(stall), 0);
      tick();
      chk("mis_pulse", 32'(misalign_err), 0);
      chk("mis_en2", 32'(mem_en), 0);
      return;
    end
    chk("acc_en", 32'(mem_en), 1);
    chk("acc_we", 32'(mem_we), 32'(wr));
    chk("acc_addr", mem_addr, addr & 32'hFFFF_FFFC);
    chk("acc_be", 32'(mem_be), 32'(ref_be(sz, off)));
    if (wr) chk("acc_wdata", mem_wdata, ref_wdata(sz, wd));
    chk("acc_stall", 32'(stall), 1);
    for (int i = 0; i < waits; i++) begin
      // Upstream noise while stalled must not disturb the access.
      req_valid = 1'(($urandom % 2));
      req_addr  = $urandom;
      req_size  = 2'($urandom);
      tick();
      chk("wait_stall", 32'(stall), 1);
      chk("wait_en", 32'(mem_en), 1);
      chk("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("wait_be", 32'(mem_be), 32'(ref_be(sz, off)));
      chk("wait_wbv", 32'(wb_valid), 0);
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk("done_en", 32'(mem_en), 0);
    chk("done_we", 32'(mem_we), 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_wbv", 32'(wb_valid), 32'(!wr));
    if (!wr) begin
      chk("done_wbdata", wb_data, exp_ld);
      chk("done_wbrd", 32'(wb_rd), 32'(rd));
    end
    tick();
    chk("post_wbv", 32'(wb_valid), 0);
    if (!wr) chk("post_hold", wb_data, exp_ld);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_rd = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b0;

    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    chk("idle_rdy_wbv", 32'(wb_valid), 0);
    chk("idle_rdy_en", 32'(mem_en), 0);

    xfer(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd5, 32'h8000_0000, 0);
    xfer(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 5'd6, 32'hBEEF_1234, 0);
    xfer(1'b1, 2'b00, 1'b0, 32'h3001, 32'h1234_56AB, 5'd7, 32'h0, 0);
    xfer(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 5'd8, 32'hCAFE_F00D, 3);
    xfer(1'b0, 2'b01, 1'b0, 32'h5001, 32'h0, 5'd9, 32'h0, 0);
    xfer(1'b1, 2'b10, 1'b0, 32'h5002, 32'h0, 5'd9, 32'h0, 0);
    xfer(1'b0, 2'b11, 1'b0, 32'h5000, 32'h0, 5'd9, 32'h0, 0);

    // Reset while an access is outstanding.
    drive_req(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 5'd10);
    tick();
    req_valid = 1'b0;
    chk("rstacc_en", 32'(mem_en), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rstacc");
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rstacc_nowb", 32'(wb_valid), 0);
    xfer(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 5'd11, 32'h1357_9BDF, 1);

    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom);
      a = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'h1 << sz) - 32'h1);
      xfer(1'($urandom), sz, 1'($urandom), a, $urandom,
           5'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  access request from EX/MEM stage; fields held stable while stall=1.
REQ-004 req_write  in  1  1=store, 0=load.
REQ-005 req_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-006 req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store source register value; low byte/half used for narrow stores.
REQ-009 req_rd  in  5  load destination register.
REQ-010 mem_en  out  1  memory request strobe, registered.
REQ-011 mem_we  out  1  memory write enable, registered.
REQ-012 mem_addr  out  32  word address, {req_addr[31:2],2'b00}, registered.
REQ-013 mem_be  out  4  byte-lane enables, registered.
REQ-014 mem_wdata  out  32  lane-replicated store data, registered.
REQ-015 mem_ready  in  1  memory completes current access this cycle; mem_rdata valid with it.
REQ-016 mem_rdata  in  32  memory read word.
REQ-017 stall  out  1  holds upstream pipeline; combinational, = (state==ACCESS).
REQ-018 wb_valid  out  1  one-cycle pulse, load result valid.
REQ-019 wb_rd  out  5  load destination, registered.
REQ-020 wb_data  out  32  extended load result, registered.
REQ-021 misalign_err  out  1  one-cycle pulse, misaligned/illegal request rejected.

Function
REQ-022 FSM states IDLE, ACCESS; reset state IDLE.
REQ-023 IDLE & req_valid & aligned: latch req_rd, req_size, req_unsigned, req_addr[1:0]; drive mem_en=1, mem_we=req_write, mem_addr, mem_be, mem_wdata; go ACCESS.
REQ-024 Aligned: byte any addr; half addr[0]=0; word addr[1:0]=00; size 11 never aligned.
REQ-025 IDLE & req_valid & not aligned: no memory access; misalign_err=1 next cycle; stay IDLE.
REQ-026 Lane map little-endian: byte at addr[1:0]=k occupies mem bits [8k+7:8k].
REQ-027 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-028 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 ACCESS: mem_en and outputs held constant until mem_ready=1 sampled.
REQ-030 ACCESS & mem_ready: next cycle mem_en=0, mem_we=0, state IDLE; stall deasserts next cycle.
REQ-031 Load completion: wb_data = selected lane (byte or half) extended to 32 bits per req_unsigned (sign from lane MSB), or full word; wb_valid=1 for exactly one cycle, the cycle after mem_ready.
REQ-032 Store completion: wb_valid stays 0.
REQ-033 Minimum latency: request cycle N, mem_en high N+1, mem_ready at N+1 gives wb_valid at N+2; each extra wait cycle adds one.
REQ-034 req_valid ignored while ACCESS (stall covers it); new request accepted in the IDLE cycle after completion.
REQ-035 wb_data, wb_rd hold last value when wb_valid=0.
REQ-036 mem_ready while IDLE ignored.

Reset
REQ-037 reset=1 at an edge forces IDLE, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_err=0, regardless of state.
REQ-038 reset mid-ACCESS abandons the access; no wb_valid for it; stall=0 the cycle after reset edge.

Verification
REQ-039 lb addr=0x1003, unsigned=0, mem_rdata=0x80_00_00_00, mem_ready immediate -> mem_be=1000, mem_addr=0x1000, wb_data=0xFFFFFF80, wb_valid one cycle at N+2.
REQ-040 lhu addr=0x2002, mem_rdata=0xBEEF1234 -> mem_be=1100, wb_data=0x0000BEEF.
REQ-041 sb addr=0x3001, wdata=0x123456AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, wb_valid never asserts.
REQ-042 lw addr=0x4000, mem_ready delayed 3 cycles -> stall high 4 cycles, mem outputs stable, wb_data=mem_rdata at N+5.
REQ-043 lh addr=0x5001; sw addr=0x5002; size=11 -> each gives misalign_err pulse, mem_en stays 0.
REQ-044 lw in ACCESS, reset asserted before mem_ready -> all outputs zero next cycle, no wb_valid, next request accepted normally.
